// File: rtl/sram_bridge.sv
// sram_bridge: valid/ready load/store port onto a 512x32 single-port SRAM macro.
// Partial-word stores run as read-modify-write because the macro has no byte mask.
module sram_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          AW        = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic          req_we,
  input  logic [3:0]    req_wstrb,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          sram_csb0,
  output logic          sram_web0,
  output logic [AW-1:0] sram_addr0,
  output logic [31:0]   sram_din0,
  input  logic [31:0]   sram_dout0
);
  typedef enum logic [1:0] {IDLE, RD, RMW, RESP} state_t;
  state_t state, state_n;
  logic [AW-1:0] addr_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   wdata_q;
  logic          ok, full, skip, acc, csb, web;
  assign ok   = req_addr[31:AW+2] == BASE_ADDR[31:AW+2] && req_addr[1:0] == 2'b00;
  assign full = req_we && req_wstrb == 4'hF;
  assign skip = !ok || (req_we && req_wstrb == 4'h0);
  assign acc  = state == IDLE && req_valid;
  assign req_ready = state == IDLE;
  always_comb begin
    state_n    = state;
    csb        = 1'b1;
    web        = 1'b1;
    sram_addr0 = addr_q;
    sram_din0  = wdata_q;
    case (state)
      IDLE: if (req_valid) begin
        state_n = skip ? RESP : !req_we ? RD : full ? RESP : RMW;
        if (!skip) begin
          csb        = 1'b0;
          web        = !full;
          sram_addr0 = req_addr[AW+1:2];
          sram_din0  = full ? req_wdata : wdata_q;
        end
      end
      RD:  state_n = RESP;
      RMW: begin
        csb     = 1'b0;
        web     = 1'b0;
        state_n = RESP;
        for (int i = 0; i < 4; i++)
          sram_din0[8*i+:8] = wstrb_q[i] ? wdata_q[8*i+:8] : sram_dout0[8*i+:8];
      end
      default: state_n = rsp_ready ? IDLE : RESP;
    endcase
  end
  // Reset overrides the macro strobes so an in-flight RMW write is abandoned.
  assign sram_csb0 = csb | rst;
  assign sram_web0 = web | rst;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      addr_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state     <= state_n;
      rsp_valid <= state_n == RESP;
      if (acc) begin
        addr_q    <= req_addr[AW+1:2];
        wstrb_q   <= req_wstrb;
        wdata_q   <= req_wdata;
        rsp_rdata <= '0;
        rsp_err   <= !ok;
      end
      if (state == RD) rsp_rdata <= sram_dout0;
    end
  end
endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: directed checks of sram_bridge against a behavioural 512x32 SRAM.
module tb_sram_bridge;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_wstrb = 0;
  logic        req_ready, rsp_valid, rsp_err, sram_csb0, sram_web0;
  logic [31:0] rsp_rdata, sram_din0, sram_dout0;
  logic [8:0]  sram_addr0, last_addr;
  logic [31:0] mem [512];
  int n_cmp = 0, n_bad = 0, n_rd = 0, n_wr = 0;

  sram_bridge dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  always #5 clk = ~clk;

  // Macro model plus access monitor.
  always @(posedge clk) if (!sram_csb0) begin
    last_addr <= sram_addr0;
    if (sram_web0) begin
      sram_dout0 <= mem[sram_addr0];
      n_rd <= n_rd + 1;
    end else begin
      mem[sram_addr0] <= sram_din0;
      n_wr <= n_wr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] d, input int hold, output int lat,
                        output logic [31:0] rd, output logic er, output int nr, output int nw);
    int r0, w0;
    r0 = n_rd;
    w0 = n_wr;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_addr = a; req_we = w; req_wstrb = s; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD; req_wstrb = 4'hA;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("rsp_dropped", rsp_valid, 0);
    nr = n_rd - r0;
    nw = n_wr - w0;
  endtask

  initial begin
    int lat, nr, nw;
    logic [31:0] rd;
    logic er;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[2] = 32'h1122_3344;
    mem[3] = 32'h5566_7788;
    req_valid = 1; req_addr = 32'h0001_0004;
    #12;
    chk("rst_csb", sram_csb0, 1);
    chk("rst_web", sram_web0, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    req_valid = 0;
    @(posedge clk); #1 rst = 0;

    do_req(32'h0001_0004, 1, 4'hF, 32'hDEAD_BEEF, 0, lat, rd, er, nr, nw);
    chk("fst_lat", lat, 1); chk("fst_err", er, 0); chk("fst_rdata", rd, 0);
    chk("fst_rd", nr, 0); chk("fst_wr", nw, 1); chk("fst_mem", mem[1], 32'hDEAD_BEEF);
    do_req(32'h0001_0004, 0, 4'h0, 0, 0, lat, rd, er, nr, nw);
    chk("ld_lat", lat, 2); chk("ld_rdata", rd, 32'hDEAD_BEEF); chk("ld_err", er, 0);
    chk("ld_rd", nr, 1); chk("ld_wr", nw, 0);

    do_req(32'h0001_0008, 1, 4'b0101, 32'hAABB_CCDD, 0, lat, rd, er, nr, nw);
    chk("rmw_lat", lat, 2); chk("rmw_err", er, 0); chk("rmw_rd", nr, 1); chk("rmw_wr", nw, 1);
    do_req(32'h0001_0008, 0, 4'h0, 0, 0, lat, rd, er, nr, nw);
    chk("rmw_load", rd, 32'h11BB_33DD);

    do_req(32'h0001_0800, 0, 4'h0, 0, 0, lat, rd, er, nr, nw);
    chk("oow_err", er, 1); chk("oow_rdata", rd, 0); chk("oow_lat", lat, 1); chk("oow_acc", nr + nw, 0);
    do_req(32'h0001_0002, 0, 4'h0, 0, 0, lat, rd, er, nr, nw);
    chk("mis_err", er, 1); chk("mis_rdata", rd, 0); chk("mis_acc", nr + nw, 0);

    do_req(32'h0001_0004, 0, 4'h0, 0, 5, lat, rd, er, nr, nw);
    chk("bp_rdata", rd, 32'hDEAD_BEEF); chk("bp_lat", lat, 2);
    chk("bp_next_ready", req_ready, 1);
    do_req(32'h0001_0008, 0, 4'h0, 0, 0, lat, rd, er, nr, nw);
    chk("bp_next_lat", lat, 2); chk("bp_next_rdata", rd, 32'h11BB_33DD);

    nw = n_wr;
    req_valid = 1; req_addr = 32'h0001_000C; req_we = 1; req_wstrb = 4'b0011; req_wdata = 32'hCAFE_BABE;
    @(posedge clk); #1;
    req_valid = 0;
    rst = 1;
    #1;
    chk("rrst_csb", sram_csb0, 1); chk("rrst_valid", rsp_valid, 0); chk("rrst_rdata", rsp_rdata, 0);
    chk("rrst_err", rsp_err, 0); chk("rrst_ready", req_ready, 1);
    @(posedge clk); #1;
    chk("rrst_no_write", n_wr - nw, 0);
    rst = 0;
    @(posedge clk); #1;
    do_req(32'h0001_000C, 0, 4'h0, 0, 0, lat, rd, er, nr, nw);
    chk("rrst_word", rd, 32'h5566_7788);

    do_req(32'h0001_07FC, 1, 4'h0, 32'h1234_5678, 0, lat, rd, er, nr, nw);
    chk("z_lat", lat, 1); chk("z_err", er, 0); chk("z_acc", nr + nw, 0);
    do_req(32'h0001_07FC, 1, 4'hF, 32'hCAFE_F00D, 0, lat, rd, er, nr, nw);
    chk("last_addr", last_addr, 511); chk("last_mem", mem[511], 32'hCAFE_F00D);
    do_req(32'h0001_07FC, 0, 4'h0, 0, 0, lat, rd, er, nr, nw);
    chk("last_load", rd, 32'hCAFE_F00D); chk("last_err", er, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- Bridges the core's valid/ready load/store port onto one 2KB single-port SRAM macro (512x32, active-low chip select and write enable, 1-cycle registered read).
- Decodes the 2KB window and rejects misaligned accesses.
- The macro has no byte mask, so partial-word stores run as read-modify-write.
- Handles one transaction at a time; sits directly upstream of the SRAM macro.

Parameters:
- BASE_ADDR, 32'h0001_0000, byte base of the SRAM window; must be 2KB aligned.
- AW, 9, SRAM word-address width (512 words).

Ports:
- clk  in  1  system clock; also drives the macro's clk0.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_wstrb  in  4  byte enables for stores; bit i = byte i.
- req_wdata  in  32  store data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  out-of-window or misaligned access.
- sram_csb0  out  1  to macro csb0, active low.
- sram_web0  out  1  to macro web0, active low.
- sram_addr0  out  AW  to macro addr0.
- sram_din0  out  32  to macro din0.
- sram_dout0  in  32  from macro dout0; valid the cycle after a selected edge.

Behaviour:
- Clock/reset: one clock (clk); rst is asynchronous, active-high.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, captured request registers 0. sram_csb0=1 and sram_web0=1 while rst is high.
- States: IDLE, RD, RMW, RESP. req_ready=1 only in IDLE.
- Decode:
  - hit = (req_addr[31:AW+2] == BASE_ADDR[31:AW+2]).
  - misaligned = (req_addr[1:0] != 0).
  - Word index = req_addr[AW+1:2].
- SRAM port drive (combinational) in IDLE on a handshake:
  - Load, hit, aligned: csb0=0, web0=1, addr0=index. Go to RD.
  - Store, wstrb=4'hF, hit, aligned: csb0=0, web0=0, din0=wdata. Write commits on this edge. Go to RESP, rsp_err=0.
  - Store, wstrb partial (not 0, not F): csb0=0, web0=1 (read). Register addr/wstrb/wdata. Go to RMW.
  - Store, wstrb=0: no SRAM access. Go to RESP, rsp_err=0.
  - Miss or misaligned: no SRAM access. Go to RESP, rsp_err=1, rsp_rdata=0.
- Default drive in all other cases: csb0=1, web0=1, addr0/din0 = registered values.
- RD: next edge captures sram_dout0 into rsp_rdata, sets rsp_valid. Go to RESP.
- RMW:
  - Drive csb0=0, web0=0, addr0=registered index.
  - din0 byte i = wstrb[i] ? wdata byte i : sram_dout0 byte i.
  - Write commits on the next edge; then RESP.
- RESP: rsp_valid=1, outputs held stable until rsp_ready=1. On that edge: rsp_valid->0, go to IDLE.
- Latency (accept edge to rsp_valid high):
  - Load: 2 cycles.
  - Full store, wstrb=0, error: 1 cycle.
  - Partial store: 2 cycles.
  - Add backpressure cycles while rsp_ready=0.
- Throughput: next request accepted no earlier than the cycle after the response handshake.
- Request inputs are don't-care outside the IDLE handshake; captured values are used.
- Reset mid-RMW: the pending write is abandoned and memory is unchanged (csb0 forced 1). Reset in RD/RESP drops the response.
- Address wrap: none. Addresses above the window are errors, never aliased.

Test Plan:
- Full store 0xDEADBEEF to 0x0001_0004, then load it -> store rsp after 1 cycle, err=0; load rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after accept; exactly one csb0 pulse per access.
- Memory holds 0x11223344 at 0x0001_0008; store wstrb=4'b0101, wdata=0xAABBCCDD -> one read then one write cycle; later load returns 0x11BB33DD.
- Load 0x0001_0800 (out of window) and load 0x0001_0002 (misaligned) -> rsp_err=1, rsp_rdata=0, sram_csb0 never low.
- Load with rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; new request accepted the cycle after the handshake.
- Assert rst during the RMW cycle of a partial store -> csb0 stays 1, word unchanged on re-read, all outputs at reset values.
- Store with wstrb=0 to 0x0001_07FC (last word) -> rsp err=0 after 1 cycle, no SRAM access; a full store then load at 0x0001_07FC hits word 511 correctly.
